// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz timing, derived totals and sync positions, and the colour-bar palette
// shared by the VGA controller files.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int RD_LAT_DEF   = 0;
    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync windows are [START, END): END is the first position after the pulse.
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    localparam int BAR_WIDTH = 80;
    localparam int BAR_COUNT = 8;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_if.sv
// Frame-buffer read port and video output bundle between the VGA controller and its surroundings.
// The read is unconditional every pixel clock: there is no valid/ready pair on this path.
interface vga_if;
    logic [9:0]  h_addr;
    logic [8:0]  v_addr;
    logic [23:0] vga_data;
    logic        TestMode;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        FrameStart;

    modport master (
        output h_addr, v_addr, vga_hsync, vga_vsync, vga_blank_n,
        output vga_r, vga_g, vga_b, FrameStart,
        input  vga_data, TestMode
    );

    modport slave (
        input  h_addr, v_addr, vga_hsync, vga_vsync, vga_blank_n,
        input  vga_r, vga_g, vga_b, FrameStart,
        output vga_data, TestMode
    );
endinterface

// File: rtl/vga_delay_line.sv
// Width/depth-parameterised shift register with synchronous clear; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = Clk ^ Rst;
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator and registered pixel output stage, aligned to a RD_LAT-cycle frame-buffer read.
// Defining VGA_TEST_PATTERN_EN adds an 8-bar colour pattern selected by TestMode.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter int   RD_LAT   = RD_LAT_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic  Clk,
    input  logic  Rst,
    vga_if.master vga
);
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = $clog2(HT);
    localparam int VW       = $clog2(VT);
    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

    // Bundle layout: {bar (pattern builds only), frame, active, vsync, hsync}
    localparam int F_HS  = 0;
    localparam int F_VS  = 1;
    localparam int F_ACT = 2;
    localparam int F_FRM = 3;
`ifdef VGA_TEST_PATTERN_EN
    localparam int FW = 7;
`else
    localparam int FW = 4;
`endif

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [31:0]   w_h;
    logic [31:0]   w_v;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_frame;
    logic [FW-1:0] w_flags_in;
    logic [FW-1:0] w_flags_dly;
    logic [23:0]   w_pixel;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_blank_n;
    logic          r_frame;
    logic [23:0]   r_rgb;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h      = 32'(r_h_cnt);
    assign w_v      = 32'(r_v_cnt);
    assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hs     = (w_h >= HS_START) && (w_h < HS_END);
    assign w_vs     = (w_v >= VS_START) && (w_v < VS_END);
    assign w_frame  = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Addresses leave straight from the counters so the buffer sees them in the counting cycle.
    assign vga.h_addr = w_active ? 10'(r_h_cnt) : '0;
    assign vga.v_addr = w_active ? 9'(r_v_cnt) : '0;

`ifdef VGA_TEST_PATTERN_EN
    logic [31:0] w_bar_idx;
    logic [2:0]  w_bar;
    assign w_bar_idx  = w_h / BAR_WIDTH;
    assign w_bar      = (w_bar_idx > (BAR_COUNT - 1)) ? 3'(BAR_COUNT - 1) : w_bar_idx[2:0];
    assign w_flags_in = {w_bar, w_frame, w_active, w_vs, w_hs};
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = vga.TestMode;
    assign w_flags_in = {w_frame, w_active, w_vs, w_hs};
`endif

    vga_delay_line #(
        .WIDTH (FW),
        .DEPTH (RD_LAT)
    ) u_align (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_data (w_flags_in),
        .o_data (w_flags_dly)
    );

    always_comb begin
        w_pixel = vga.vga_data;
`ifdef VGA_TEST_PATTERN_EN
        if (vga.TestMode) w_pixel = bar_colour(w_flags_dly[6:4]);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hsync   <= ~SYNC_POL;
            r_vsync   <= ~SYNC_POL;
            r_blank_n <= 1'b0;
            r_frame   <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_hsync   <= w_flags_dly[F_HS] ? SYNC_POL : ~SYNC_POL;
            r_vsync   <= w_flags_dly[F_VS] ? SYNC_POL : ~SYNC_POL;
            r_blank_n <= w_flags_dly[F_ACT];
            r_frame   <= w_flags_dly[F_FRM];
            r_rgb     <= w_flags_dly[F_ACT] ? w_pixel : '0;
        end
    end

    assign vga.vga_hsync   = r_hsync;
    assign vga.vga_vsync   = r_vsync;
    assign vga.vga_blank_n = r_blank_n;
    assign vga.FrameStart  = r_frame;
    assign vga.vga_r       = r_rgb[23:16];
    assign vga.vga_g       = r_rgb[15:8];
    assign vga.vga_b       = r_rgb[7:0];
endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA timing generator and pixel output stage for the Vga peripheral. It drives the frame-buffer read address (`h_addr`, `v_addr`) and consumes the returned 24-bit `vga_data`. It produces `vga_hsync`, `vga_vsync`, the blanking signal and RGB, all phase-aligned to the buffer's read latency. Default timing is 640x480@60 Hz with a 25.175 MHz pixel clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`/`H_SYNC`/`H_BP`, 16/96/48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP`/`V_SYNC`/`V_BP`, 10/2/33, vertical porch and sync widths in lines
- `RD_LAT`, 0, frame-buffer read latency in cycles (0..3)
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `Clk` in 1: pixel clock, single clock domain
- `Rst` in 1: synchronous, active-high reset
- `h_addr` out 10: pixel column to frame buffer; 0 outside the active region
- `v_addr` out 9: pixel row to frame buffer; 0 outside the active region
- `vga_data` in 24: pixel from frame buffer, {R,G,B}, valid `RD_LAT` cycles after the address
- `TestMode` in 1: selects the colour-bar pattern (see Configuration)
- `vga_hsync`, `vga_vsync` out 1: sync outputs
- `vga_blank_n` out 1: high during the active region
- `vga_r`, `vga_g`, `vga_b` out 8 each: colour outputs
- `FrameStart` out 1: one-cycle pulse with the first active pixel of each frame

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - `v_cnt` runs 0..V_TOTAL-1, where V_TOTAL = 525. It increments when `h_cnt` wraps.
  - Both wrap together at (799, 524) → (0, 0).
- Region order per axis: active, front porch, sync, back porch.
  - Hsync is asserted for `h_cnt` in 656..751.
  - Vsync is asserted for `v_cnt` in 490..491.
- Address generation is combinational from the counter registers.
  - Active pixel: `h_addr = h_cnt`, `v_addr = v_cnt`.
  - Any other pixel: both are 0.
- Alignment:
  - hsync, vsync, active flag, frame-start flag and bar index pass through a delay line of `RD_LAT` stages.
  - They then enter the registered output stage.
- Output stage:
  - RGB = `vga_data` when the delayed active flag is 1, else 0.
  - `vga_blank_n` = delayed active flag.
- Sync polarity: sync output level = asserted ? `SYNC_POL` : ~`SYNC_POL`.
- Reset values:
  - Counters = 0 and all delay stages cleared.
  - `vga_hsync`/`vga_vsync` = ~`SYNC_POL`.
  - `vga_blank_n` = 0, RGB = 0, `FrameStart` = 0.
- Reset mid-frame: outputs take reset values the cycle after `Rst` is sampled high. Counting restarts at (0,0) on the first cycle after release. No partial-width sync pulse may follow.

## Timing
- Latency: counter state at cycle t appears on all registered outputs at t + `RD_LAT` + 1.
- `h_addr`/`v_addr` change in the same cycle as the counters.
- `FrameStart` is high exactly one cycle per 420000, coincident with pixel (0,0) on the outputs.
- The frame buffer write side is independent. No handshake exists on the read path; the read is strictly every cycle.

## Configuration
- `VGA_TEST_PATTERN_EN`, when defined: `TestMode` = 1 replaces `vga_data` at the output stage with 8 vertical bars, each 80 px wide. Colours in order:
  - white `FFFFFF`, yellow `FFFF00`, cyan `00FFFF`, green `00FF00`
  - magenta `FF00FF`, red `FF0000`, blue `0000FF`, black `000000`
- Bar index is computed at counter stage and delayed with the sync signals. `TestMode` is sampled at the output stage.
- When undefined: `TestMode` is ignored, no pattern logic is present, and RGB always comes from `vga_data`.

## Structure
- Package `vga_pkg`: default timing constants, derived totals (H_TOTAL/V_TOTAL and sync start/end positions), bar colour constants.
- Sub-module `vga_delay_line`: parameterised width/depth shift register with synchronous clear. Depth 0 is a pass-through. It is used for the sync/active/frame/bar bundle.

## Test plan
- Reset, run 800 cycles, `RD_LAT`=0 → `vga_hsync` low for exactly 96 consecutive cycles, falling 657 cycles after the counter's h=0; `vga_blank_n` high for exactly 640 cycles per line.
- Run 2 frames → `vga_vsync` low for exactly 1600 cycles per frame; `FrameStart` pulses are 420000 cycles apart.
- At counter (639,479) → `h_addr`=639, `v_addr`=479. At (640,479) → both 0 and, one cycle later, `vga_blank_n`=0 and RGB=0.
- `RD_LAT`=2, memory model with `vga_data`={5'b0,h_addr,v_addr} delayed 2 cycles → output RGB at cycle t+3 equals the encoding of the address at t, for every active pixel.
- `Rst` asserted at (300,200) → next cycle hsync/vsync inactive, blank_n=0, RGB=0. After release, `h_addr` counts 0,1,2….
- With `VGA_TEST_PATTERN_EN` and `TestMode`=1 → RGB at h=0 is `FFFFFF`, h=80 is `FFFF00`, h=639 is `000000`. With `TestMode`=0, RGB equals `vga_data`.
